// File: rtl/lfa_serial_wide_adder.sv
// Multi-word serial adder: streams WORDS 12-bit slices, LSB first, through a
// 12-bit Ladner-Fischer prefix adder and carries between slices in a register.

module UBPriLFA_11_0 (
  input  logic [11:0] X,
  input  logic [11:0] Y,
  input  logic        Cin,
  output logic [12:0] S
);

  // Position 0 of the prefix tree is the carry-in; position i+1 is bit i.
  function automatic logic [12:0] lf_carries(input logic [12:0] g_in,
                                             input logic [12:0] p_in);
    logic [12:0] g_c;
    logic [12:0] p_c;
    logic [12:0] g_n;
    logic [12:0] p_n;
    int          j;
    g_c = g_in;
    p_c = p_in;
    for (int l = 0; l < 4; l++) begin
      g_n = g_c;
      p_n = p_c;
      for (int i = 0; i < 13; i++) begin
        if (((i >> l) & 1) == 1) begin
          j = ((i >> l) << l) - 1;
          g_n[i] = g_c[i] | (p_c[i] & g_c[j]);
          p_n[i] = p_c[i] & p_c[j];
        end
      end
      g_c = g_n;
      p_c = p_n;
    end
    return g_c;
  endfunction

  logic [11:0] half_sum;
  logic [12:0] carry_vec;

  assign half_sum  = X ^ Y;
  assign carry_vec = lf_carries({X & Y, Cin}, {half_sum, 1'b0});
  assign S         = {carry_vec[12], half_sum ^ carry_vec[11:0]};

endmodule

module lfa_serial_wide_adder #(
  parameter int WORDS = 4,
  parameter int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORDS*12-1:0]   in_a,
  input  logic [WORDS*12-1:0]   in_b,
  input  logic                  in_cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORDS*12:0]     out_sum,
  output logic                  busy
);

  localparam int SW   = 12;
  localparam int TOPB = WORDS * SW;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q;
  logic [TOPB-1:0]    a_q;
  logic [TOPB-1:0]    b_q;
  logic               carry_q;
  logic [IDX_W-1:0]   idx_q;
  logic [TOPB:0]      sum_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;

  logic [31:0]        base;
  logic [SW-1:0]      x_s;
  logic [SW-1:0]      y_s;
  logic [SW:0]        s_core;
  logic               last_slice;

  assign base       = 32'(idx_q) * 32'(SW);
  assign x_s        = a_q[base +: SW];
  assign y_s        = b_q[base +: SW];
  assign last_slice = (idx_q == IDX_W'(WORDS - 1));

  UBPriLFA_11_0 u_core (
    .X   (x_s),
    .Y   (y_s),
    .Cin (carry_q),
    .S   (s_core)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      sum_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= in_a;
            b_q        <= in_b;
            carry_q    <= in_cin;
            idx_q      <= '0;
            sum_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end
        end
        // One slice per cycle; the carry-out of the top slice becomes the sum MSB.
        RUN: begin
          sum_q[base +: SW] <= s_core[SW-1:0];
          carry_q           <= s_core[SW];
          if (last_slice) begin
            sum_q[TOPB] <= s_core[SW];
            idx_q       <= '0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  assign busy      = busy_q;

endmodule
